sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Purpose
//   Merges the instruction-fetch port and the load/store port of a CPU core
//   onto one SRAM-style bus that has split address and data handshakes.
//   At most one bus transaction is in flight. Data accesses win arbitration.
//   The exception is when instruction fetch has been passed over STARVE_LIMIT
//   times in a row; fetch then gets the next grant.
//
// Handshake semantics
//   Requester side: a requester raises *_req with its fields. It holds the
//   request and the fields stable until its *_ready pulse, which lasts exactly
//   one cycle and carries *_rdata. If a request is still high in the cycle
//   after that pulse, it is a new request.
//   Bus side: mem_req with the address/write fields is the address-phase
//   valid, and mem_addr_ok is its ready. Both are sampled on the same rising
//   edge. After acceptance, mem_data_ok marks the response; for reads it
//   carries mem_rdata. A handshake input outside its own phase is ignored.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   inst_req/addr            fetch request and address
//   inst_rdata/ready         fetch data and one-cycle completion pulse
//   data_req/wen/addr/wdata  load/store request (wen == 0 means load)
//   data_rdata/ready         load data (also updated on stores), completion
//   stallreq_for_mem         stall request to the pipeline stall controller
//   mem_req/wr/wstrb/addr/wdata   unified bus address phase
//   mem_addr_ok              bus accepted the address phase
//   mem_data_ok/rdata        bus response (read data or write done)
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,

  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,

  output logic        stallreq_for_mem,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // The streak counter must be able to hold STARVE_LIMIT itself.
  localparam int unsigned STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request; arbitration happens here
    REQ  = 2'd1,  // address phase on the bus, waiting for mem_addr_ok
    RESP = 2'd2,  // address accepted, waiting for mem_data_ok
    DONE = 2'd3   // owner's ready pulse is high this cycle
  } state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  state_t              state;
  owner_t              owner;
  logic [STREAK_W-1:0] streak;

  // Arbitration decision for the IDLE cycle.
  // starve: fetch is waiting and has already been passed over the maximum
  // number of times, so this grant goes to fetch even if data is pending.
  logic starve;
  logic grant_data;
  logic grant_inst;

  always_comb begin
    starve     = inst_req & (streak == STREAK_MAX);
    grant_data = data_req & ~starve;
    grant_inst = inst_req & ~grant_data;
  end

  // The stall is combinational. The pipeline can then release in the same
  // cycle as the ready pulse, and no bubble is added after each access.
  assign stallreq_for_mem = (inst_req & ~inst_ready) | (data_req & ~data_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWNER_INST;
      streak     <= '0;
      inst_rdata <= '0;
      inst_ready <= 1'b0;
      data_rdata <= '0;
      data_ready <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Ready outputs are pulses. They are high only in the cycle after the
      // RESP -> DONE transition.
      inst_ready <= 1'b0;
      data_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_data) begin
            owner     <= OWNER_DATA;
            mem_req   <= 1'b1;
            mem_wr    <= |data_wen;
            mem_wstrb <= data_wen;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            state     <= REQ;
            // Count only the grants that actually passed over a waiting fetch.
            if (inst_req && (streak != STREAK_MAX)) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (grant_inst) begin
            owner     <= OWNER_INST;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
            state     <= REQ;
            streak    <= '0;
          end
        end

        REQ: begin
          // The address fields stay latched from the grant edge. Only
          // mem_req changes when the bus accepts. If data_ok arrives in the
          // same cycle, it belongs to no accepted transaction yet.
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end

        RESP: begin
          if (mem_data_ok) begin
            // Writes also return through here. data_rdata then picks up
            // whatever the bus drives with the write completion.
            if (owner == OWNER_DATA) begin
              data_rdata <= mem_rdata;
              data_ready <= 1'b1;
            end else begin
              inst_rdata <= mem_rdata;
              inst_ready <= 1'b1;
            end
            state <= DONE;
          end
        end

        DONE: begin
          // No arbitration here. A request still high in the next IDLE cycle
          // is treated as a fresh request.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter. Each cycle:
//   - the requesters drive the DUT from per-port work queues,
//   - a responder answers the bus with programmable delays and can inject
//     spurious handshakes,
//   - the outputs are compared against a transaction-level reference.
// The reference keeps the in-flight transaction as a record with flags. It
// keeps the expected bus fields in exp_q, and it keeps the starvation streak
// as a plain integer.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        stallreq_for_mem;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_rdata       (inst_rdata),
    .inst_ready       (inst_ready),
    .data_req         (data_req),
    .data_wen         (data_wen),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_rdata       (data_rdata),
    .data_ready       (data_ready),
    .stallreq_for_mem (stallreq_for_mem),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_wstrb        (mem_wstrb),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok),
    .mem_rdata        (mem_rdata)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit checks_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // stimulus knobs
  int a_min = 0, a_max = 0, d_min = 0, d_max = 0;
  int spur_pct = 0, gap_pct = 0;
  bit do_rst = 1'b1;

  // requesters
  logic [31:0] inst_todo[$];
  dreq_t       data_todo[$];
  bit inst_active = 0, data_active = 0;
  bit inst_rdy_seen = 0, data_rdy_seen = 0;
  int issued_cnt = 0;

  // bus responder
  int bus_phase = 0;  // 0 none, 1 address wait, 2 data wait
  int bus_cnt   = 0;
  logic [31:0] bus_rdata_q[$];

  // reference model
  bit m_busy = 0, m_acc = 0, m_done = 0, m_owner_data = 0, m_post_rst = 0;
  int m_streak = 0;
  logic [31:0] m_inst_rdata = '0, m_data_rdata = '0;
  logic [69:0] exp_q[$];  // {owner_data, wr, wstrb, addr, wdata}

  // observations
  int inst_rdy_cnt = 0, data_rdy_cnt = 0;
  bit done_log[$];  // 1 = data completion, 0 = fetch completion

  // ---------------- driver tasks ----------------
  task automatic drive_requesters();
    dreq_t d;
    if (do_rst) begin
      inst_active = 0;
      data_active = 0;
    end
    if (inst_active && inst_rdy_seen) inst_active = 0;
    if (!inst_active && inst_todo.size() > 0 && !do_rst && $urandom_range(99) >= gap_pct) begin
      inst_active = 1;
      inst_addr   = inst_todo.pop_front();
      issued_cnt++;
    end
    if (!inst_active) inst_addr = $urandom;
    inst_req = inst_active;

    if (data_active && data_rdy_seen) data_active = 0;
    if (!data_active && data_todo.size() > 0 && !do_rst && $urandom_range(99) >= gap_pct) begin
      d           = data_todo.pop_front();
      data_active = 1;
      data_wen    = d.wen;
      data_addr   = d.addr;
      data_wdata  = d.wdata;
      issued_cnt++;
    end
    if (!data_active) begin
      data_wen   = 4'($urandom);
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    data_req = data_active;
  endtask

  task automatic drive_bus();
    int ph0;
    ph0 = bus_phase;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom;
    if (bus_phase == 2) begin
      if (bus_cnt == 0) begin
        mem_data_ok = 1'b1;
        if (bus_rdata_q.size() > 0) mem_rdata = bus_rdata_q.pop_front();
        bus_phase = 0;
      end else begin
        bus_cnt--;
      end
    end else begin
      if (bus_phase == 0 && mem_req) begin
        bus_phase = 1;
        bus_cnt   = $urandom_range(a_max, a_min);
      end
      if (bus_phase == 1) begin
        if (bus_cnt == 0) begin
          mem_addr_ok = 1'b1;
          bus_phase   = 2;
          bus_cnt     = $urandom_range(d_max, d_min);
        end else begin
          bus_cnt--;
        end
      end
    end
    // Handshakes the arbiter must ignore: addr_ok with no address phase
    // offered, and data_ok while nothing accepted is awaiting a response.
    if (spur_pct > 0) begin
      if (!mem_req && !mem_addr_ok && $urandom_range(99) < spur_pct) mem_addr_ok = 1'b1;
      if (ph0 != 2 && !mem_data_ok && $urandom_range(99) < spur_pct) mem_data_ok = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic exp_ir, exp_dr, exp_mreq;
    logic [69:0] e;
    exp_ir   = m_done && !m_owner_data;
    exp_dr   = m_done && m_owner_data;
    exp_mreq = m_busy && !m_acc;
    if (checks_on) begin
      check("mem_req", mem_req, exp_mreq);
      if (exp_mreq && exp_q.size() > 0) begin
        e = exp_q[0];
        check("mem_addr", mem_addr, e[63:32]);
        check("mem_wr", mem_wr, e[68]);
        check("mem_wstrb", mem_wstrb, e[67:64]);
        if (e[69]) check("mem_wdata", mem_wdata, e[31:0]);
      end
      check("inst_ready", inst_ready, exp_ir);
      check("data_ready", data_ready, exp_dr);
      check("inst_rdata", inst_rdata, m_inst_rdata);
      check("data_rdata", data_rdata, m_data_rdata);
      check("stall", stallreq_for_mem, (inst_req & ~exp_ir) | (data_req & ~exp_dr));
      if (m_post_rst) begin
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_mem_wr", mem_wr, 0);
      end
    end
    inst_rdy_seen = inst_ready;
    data_rdy_seen = data_ready;
    if (inst_ready) begin inst_rdy_cnt++; done_log.push_back(1'b0); end
    if (data_ready) begin data_rdy_cnt++; done_log.push_back(1'b1); end
  endtask

  // The reference advances on what the DUT sees at the closing edge.
  task automatic model_update();
    m_post_rst = 0;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_done = 0; m_streak = 0;
      m_inst_rdata = '0; m_data_rdata = '0;
      exp_q.delete();
      m_post_rst = 1;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (data_req && !(inst_req && m_streak == LIMIT)) begin
        m_busy = 1; m_acc = 0; m_owner_data = 1;
        exp_q.push_back({1'b1, |data_wen, data_wen, data_addr, data_wdata});
        if (inst_req) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
      end else if (inst_req) begin
        m_busy = 1; m_acc = 0; m_owner_data = 0;
        exp_q.push_back({1'b0, 1'b0, 4'h0, inst_addr, 32'h0});
        m_streak = 0;
      end
    end else if (!m_acc) begin
      if (mem_addr_ok) begin
        m_acc = 1;
        void'(exp_q.pop_front());
      end
    end else if (mem_data_ok) begin
      m_done = 1;
      if (m_owner_data) m_data_rdata = mem_rdata;
      else m_inst_rdata = mem_rdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = do_rst;
    drive_requesters();
    drive_bus();
    #1;
    check_outputs();
    model_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int limit);
    bit quiet;
    int n;
    n = 0;
    quiet = 0;
    while (!quiet && n < limit) begin
      tick();
      n++;
      quiet = (inst_todo.size() == 0) && (data_todo.size() == 0) &&
              !inst_active && !data_active && !m_busy;
    end
    check("drain_quiet", quiet, 1);
  endtask

  task automatic set_bus(input int amin, input int amax, input int dmin, input int dmax);
    a_min = amin; a_max = amax; d_min = dmin; d_max = dmax;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit exp_pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int mreq_cnt, stall_cnt, rdy_cnt, rdy_cyc, rdy_before, mreq_seen;
    dreq_t d;

    // Reset: the outputs are undefined before the first reset edge.
    do_rst = 1;
    checks_on = 0;
    tick();
    checks_on = 1;
    tick();
    do_rst = 0;
    tick();

    // Single fetch with the minimum latency.
    set_bus(0, 0, 0, 0);
    bus_rdata_q.push_back(32'h3C1D0001);
    inst_todo.push_back(32'hBFC00000);
    tick();                                   // cycle 0
    tick();                                   // cycle 1
    check("s1_mem_req", mem_req, 1);
    check("s1_mem_addr", mem_addr, 32'hBFC00000);
    check("s1_mem_wr", mem_wr, 0);
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    check("s1_inst_ready", inst_ready, 1);
    check("s1_inst_rdata", inst_rdata, 32'h3C1D0001);
    drain(50);

    // Simultaneous requests: data goes first, and fetch starts after it.
    data_todo.push_back('{wen: 4'hF, addr: 32'h80000010, wdata: 32'hDEADBEEF});
    inst_todo.push_back(32'hBFC00004);
    tick();                                   // cycle 0
    tick();                                   // cycle 1
    check("s2_mem_wr", mem_wr, 1);
    check("s2_mem_wstrb", mem_wstrb, 4'hF);
    check("s2_mem_addr", mem_addr, 32'h80000010);
    check("s2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    tick();                                   // cycle 3
    check("s2_data_ready", data_ready, 1);
    check("s2_inst_ready", inst_ready, 0);
    tick();                                   // cycle 4: IDLE
    check("s2_idle_mem_req", mem_req, 0);
    tick();                                   // cycle 5
    check("s2_inst_mem_req", mem_req, 1);
    check("s2_inst_mem_addr", mem_addr, 32'hBFC00004);
    check("s2_inst_mem_wr", mem_wr, 0);
    drain(50);

    // Starvation: data is back-to-back while fetch keeps waiting.
    done_log.delete();
    for (int i = 0; i < 12; i++) begin
      d.wen = 4'($urandom); d.addr = $urandom; d.wdata = $urandom;
      data_todo.push_back(d);
    end
    inst_todo.push_back(32'hBFC00100);
    inst_todo.push_back(32'hBFC00104);
    drain(400);
    check("s3_completions", done_log.size(), 14);
    for (int i = 0; i < 10; i++) begin
      if (i < done_log.size()) check($sformatf("s3_order_%0d", i), done_log[i], exp_pat[i]);
    end

    // Slow bus: address accepted 5 cycles late, response 3 cycles after that.
    set_bus(5, 5, 2, 2);
    data_todo.push_back('{wen: 4'h0, addr: 32'h80001234, wdata: 32'h0});
    mreq_cnt = 0; stall_cnt = 0; rdy_cnt = 0; rdy_cyc = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mem_req) mreq_cnt++;
      if (stallreq_for_mem) stall_cnt++;
      if (data_ready) begin rdy_cnt++; rdy_cyc = i; end
    end
    check("s4_mem_req_cycles", mreq_cnt, 6);
    check("s4_stall_cycles", stall_cnt, 10);
    check("s4_ready_pulses", rdy_cnt, 1);
    check("s4_ready_cycle", rdy_cyc, 10);
    drain(50);

    // Reset in RESP. The bus is not reset, so its late data_ok is stray.
    set_bus(0, 0, 1, 1);
    inst_todo.push_back(32'hBFC00200);
    rdy_before = inst_rdy_cnt + data_rdy_cnt;
    tick();                                   // cycle 0
    tick();                                   // cycle 1: addr_ok
    do_rst = 1;
    tick();                                   // cycle 2: rst high
    do_rst = 0;
    tick();                                   // cycle 3: stray data_ok
    check("s5_mem_req", mem_req, 0);
    check("s5_mem_addr", mem_addr, 0);
    check("s5_mem_wstrb", mem_wstrb, 0);
    check("s5_inst_ready", inst_ready, 0);
    check("s5_data_ready", data_ready, 0);
    check("s5_inst_rdata", inst_rdata, 0);
    check("s5_data_rdata", data_rdata, 0);
    check("s5_stall", stallreq_for_mem, 0);
    run(5);
    check("s5_no_ready", inst_rdy_cnt + data_rdy_cnt, rdy_before);

    // Spurious handshakes while idle.
    spur_pct = 100;
    rdy_before = inst_rdy_cnt + data_rdy_cnt;
    mreq_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req) mreq_seen++;
    end
    check("s6_no_ready", inst_rdy_cnt + data_rdy_cnt, rdy_before);
    check("s6_no_mem_req", mreq_seen, 0);
    spur_pct = 0;
    bus_phase = 0;

    // Random soak: delays, gaps, spurious handshakes and mixed traffic.
    set_bus(0, 3, 0, 3);
    spur_pct = 15;
    gap_pct = 40;
    issued_cnt = 0;
    rdy_before = inst_rdy_cnt + data_rdy_cnt;
    for (int i = 0; i < 2500; i++) begin
      if (inst_todo.size() < 2 && $urandom_range(9) < 3) inst_todo.push_back($urandom);
      if (data_todo.size() < 2 && $urandom_range(9) < 4) begin
        d.wen   = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        d.addr  = $urandom;
        d.wdata = $urandom;
        data_todo.push_back(d);
      end
      tick();
    end
    drain(1000);
    check("soak_all_completed", inst_rdy_cnt + data_rdy_cnt - rdy_before, issued_cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
